// File: rtl/pass_checker.sv
// Code-entry sequencer: reads the stored code length and digits from a 16x4 ROM,
// compares user digits, pulses grant/deny, and enforces a timed lockout.
module pass_checker #(
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 16,
  parameter int ROM_LAT     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  output logic       key_ready,
  output logic [3:0] rom_addr,
  output logic       rom_cs,
  input  logic [3:0] rom_data,
  output logic       grant,
  output logic       deny,
  output logic       locked,
  output logic       busy,
  output logic [3:0] fail_cnt
);

  localparam int TW = $clog2(LOCK_CYCLES + 1);
  localparam int LW = $clog2(ROM_LAT + 1);

  typedef enum logic [2:0] {
    IDLE, RD_LEN, WAIT_LEN, WAIT_KEY, FETCH, WAIT_DIG, DONE, LOCKED
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     len_q, len_d;
  logic [3:0]     idx_q, idx_d;
  logic           mis_q, mis_d;
  logic [3:0]     dig_q, dig_d;
  logic [LW-1:0]  lat_q, lat_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [3:0]     addr_q, addr_d;
  logic [3:0]     fail_q, fail_d;
  logic [3:0]     fail_inc;

  assign fail_inc = (fail_q == 4'hF) ? 4'hF : fail_q + 4'd1;
  assign rom_addr = addr_q;
  assign fail_cnt = fail_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      mis_q   <= 1'b0;
      dig_q   <= '0;
      lat_q   <= '0;
      timer_q <= '0;
      addr_q  <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      mis_q   <= mis_d;
      dig_q   <= dig_d;
      lat_q   <= lat_d;
      timer_q <= timer_d;
      addr_q  <= addr_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    mis_d     = mis_q;
    dig_d     = dig_q;
    lat_d     = lat_q;
    timer_d   = timer_q;
    addr_d    = addr_q;
    fail_d    = fail_q;
    key_ready = 1'b0;
    rom_cs    = 1'b0;
    grant     = 1'b0;
    deny      = 1'b0;
    locked    = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = RD_LEN;
          idx_d   = '0;
          mis_d   = 1'b0;
          addr_d  = '0;
        end
      end
      RD_LEN: begin
        rom_cs  = 1'b1;
        lat_d   = LW'(1);
        state_d = WAIT_LEN;
      end
      WAIT_LEN: begin
        if (lat_q == LW'(ROM_LAT)) begin
          len_d = rom_data;
          if (rom_data == 4'd0) begin
            mis_d   = 1'b1;
            state_d = DONE;
          end else begin
            idx_d   = 4'd1;
            state_d = WAIT_KEY;
          end
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      WAIT_KEY: begin
        key_ready = 1'b1;
        if (key_valid) begin
          dig_d   = key_digit;
          addr_d  = idx_q;
          state_d = FETCH;
        end
      end
      FETCH: begin
        rom_cs  = 1'b1;
        lat_d   = LW'(1);
        state_d = WAIT_DIG;
      end
      WAIT_DIG: begin
        // Every digit is taken even after a mismatch so attempt timing leaks nothing.
        if (lat_q == LW'(ROM_LAT)) begin
          mis_d = mis_q | (rom_data != dig_q);
          if (idx_q == len_q) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = WAIT_KEY;
          end
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!mis_q) begin
          grant  = 1'b1;
          fail_d = '0;
        end else begin
          deny   = 1'b1;
          fail_d = fail_inc;
          if (fail_inc == 4'(MAX_FAIL)) begin
            timer_d = TW'(LOCK_CYCLES);
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        busy   = 1'b0;
        locked = 1'b1;
        if (timer_q <= TW'(1)) begin
          timer_d = '0;
          fail_d  = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort discards everything in flight, including a digit offered this cycle.
    if (abort && busy) begin
      state_d = IDLE;
      grant   = 1'b0;
      deny    = 1'b0;
      fail_d  = fail_q;
      timer_d = timer_q;
      addr_d  = addr_q;
    end
  end

endmodule

// File: doc/pass_checker.md
Name: pass_checker

Overview:
- Sequencer for the 16x4 stored-code ROM.
- On a start request it reads the code length from ROM word 0, then accepts user digits one at a time, fetching ROM words 1..L and comparing each digit.
- Issues one grant or deny pulse per attempt, counts consecutive failures, and enforces a timed lockout.
- Sits between the keypad front-end and the ROM; it is the only driver of the ROM address and chip-select.

Parameters:
- MAX_FAIL, 3: consecutive denied attempts that trigger lockout (1..15).
- LOCK_CYCLES, 16: clock cycles spent in LOCKED (>=1).
- ROM_LAT, 1: cycles from the rom_cs-high cycle to the cycle in which rom_data is sampled (>=1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin attempt; honoured only in IDLE.
- abort  in  1  cancel attempt; honoured in any state except IDLE and LOCKED.
- key_valid  in  1  digit offered.
- key_digit  in  4  digit value.
- key_ready  out  1  high only in WAIT_KEY; a digit is accepted when key_valid and key_ready are both high.
- rom_addr  out  4  ROM word address.
- rom_cs  out  1  one-cycle read strobe; the ROM captures on its rising edge.
- rom_data  in  4  ROM word.
- grant  out  1  one-cycle pulse: code matched.
- deny  out  1  one-cycle pulse: code mismatched or invalid length.
- locked  out  1  high throughout LOCKED.
- busy  out  1  high in every state except IDLE and LOCKED.
- fail_cnt  out  4  consecutive denied attempts.

Behaviour:
- Reset (async): state IDLE. All outputs 0, rom_addr 0, idx 0, len 0, mismatch flag 0, lock timer 0.
- ROM layout: word 0 = code length L; words 1..L = code digits.
- Register set: len (4b), idx (4b), mismatch (1b), lock timer (clog2(LOCK_CYCLES+1) b).
- States: IDLE, RD_LEN, WAIT_LEN, WAIT_KEY, FETCH, WAIT_DIG, DONE, LOCKED.
- IDLE: on start go to RD_LEN; clear idx and mismatch.
- RD_LEN: rom_addr=0, rom_cs=1 for exactly this cycle, then go to WAIT_LEN.
- WAIT_LEN: stay ROM_LAT cycles, counted from the RD_LEN cycle; on the last one, latch len=rom_data.
  - len==0: go to DONE with mismatch=1.
  - otherwise: go to WAIT_KEY with idx=1.
- WAIT_KEY: on key accept, register key_digit and go to FETCH.
- FETCH: rom_addr=idx, rom_cs=1 for this cycle only, then go to WAIT_DIG.
- WAIT_DIG: on the ROM_LAT-th cycle after FETCH, compare rom_data with the registered digit and OR the result into mismatch.
  - idx==len: go to DONE.
  - otherwise: increment idx and go to WAIT_KEY.
- Early mismatch does not shorten the attempt; all L digits are always taken, so timing is data-independent.
- Digit latency with ROM_LAT=1: accept in cycle k, rom_cs in k+1, compare in k+2, key_ready high again in k+3.
- DONE (one cycle):
  - mismatch=0: grant=1, fail_cnt cleared, then IDLE.
  - mismatch=1: deny=1, fail_cnt incremented (saturates at 15). If the new fail_cnt==MAX_FAIL, load the lock timer with LOCK_CYCLES and go to LOCKED; else go to IDLE.
- LOCKED:
  - locked=1; start, abort and keys are ignored.
  - Timer decrements each cycle; at 0 go to IDLE and clear fail_cnt.
  - locked is high for exactly LOCK_CYCLES cycles.
- abort: the next state is IDLE. No grant or deny pulse, fail_cnt unchanged, and any rom_cs already issued is not repeated.
- Simultaneous abort and key accept: abort wins; the digit is discarded.
- start outside IDLE is ignored. key_valid outside WAIT_KEY is ignored and the digit is not buffered.
- rom_cs is never high in two consecutive cycles.
- rom_addr holds its last value when rom_cs=0.
- Reset mid-attempt or mid-lockout returns immediately to the reset values, including fail_cnt=0.

Test Plan:
- ROM words 0..5 = 5,F,1,A,1,7. Start, then keys F,1,A,1,7 -> rom_cs pulses at addrs 0,1,2,3,4,5; grant pulse 1 cycle after the compare of the 5th digit; fail_cnt=0.
- Same ROM, keys F,2,A,1,7 -> all 5 digits consumed; deny pulse; fail_cnt=1; back in IDLE.
- Three wrong attempts, MAX_FAIL=3, LOCK_CYCLES=16 -> third deny is followed by locked=1 for exactly 16 cycles; start during lockout is ignored; after lockout fail_cnt=0 and a correct attempt grants.
- ROM word 0 = 0 -> start produces deny with no key_ready assertion and fail_cnt=1.
- abort asserted after 2 digits, same cycle as a key_valid -> IDLE next cycle, no pulse, fail_cnt unchanged, busy=0; a following correct attempt grants.
- rst asserted mid-FETCH and mid-LOCKED -> all outputs 0 asynchronously; fail_cnt=0. With ROM_LAT=2, the data compare occurs 2 cycles after rom_cs.
